// File: rtl/psram_pattern_tester_pkg.sv
// rtl/psram_pattern_tester_pkg.sv - shared types and LFSR tap table for the PSRAM pattern tester
// Galois taps are only consumed when PSRAM_TESTER_LFSR_EN is defined.
package psram_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_ISSUE,
    ST_WR_WAIT_LO,
    ST_WR_WAIT_HI,
    ST_RD_ISSUE,
    ST_RD_WAIT_LO,
    ST_RD_WAIT_HI,
    ST_PASS_END
  } state_e;

  typedef enum logic [1:0] {
    MODE_INDEX = 2'd0,
    MODE_INV   = 2'd1,
    MODE_WALK  = 2'd2,
    MODE_LFSR  = 2'd3
  } mode_e;

  localparam logic [15:0] FILL_WORD = 16'hA5A5;

  // Right-shifting Galois masks for maximal-length polynomials.
  function automatic logic [63:0] lfsr_taps(input int unsigned width);
    case (width)
      8:       lfsr_taps = 64'h0000_0000_0000_00B8;
      16:      lfsr_taps = 64'h0000_0000_0000_B400;
      24:      lfsr_taps = 64'h0000_0000_00E1_0000;
      32:      lfsr_taps = 64'h0000_0000_8020_0003;
      default: lfsr_taps = 64'hD800_0000_0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/psram_pattern_tester_if.sv
// rtl/psram_pattern_tester_if.sv - ready/strobe memory-controller port of the pattern tester
interface psram_pattern_tester_if #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 16
) ();
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_read_strb;
  logic              mem_write_strb;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  mem_ready, mem_rdata,
    output mem_addr, mem_read_strb, mem_write_strb, mem_wdata
  );

  modport slave (
    output mem_ready, mem_rdata,
    input  mem_addr, mem_read_strb, mem_write_strb, mem_wdata
  );
endinterface

// File: rtl/psram_pattern_gen.sv
// rtl/psram_pattern_gen.sv - word generator per index/mode; PSRAM_TESTER_LFSR_EN adds the LFSR step
// Without the macro mode 3 emits a fixed 0xA5A5 fill and has no LFSR ports.
module psram_pattern_gen
  import psram_tester_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int DATA_W     = 16
) (
  input  logic [DEPTH_LOG2-1:0] idx_i,
  input  mode_e                 mode_i,
`ifdef PSRAM_TESTER_LFSR_EN
  input  logic [DATA_W-1:0]     lfsr_i,
  output logic [DATA_W-1:0]     lfsr_next_o,
`endif
  output logic [DATA_W-1:0]     word_o
);

  logic [DATA_W-1:0] idx_word;
  logic [DATA_W-1:0] walk_word;
  logic [DATA_W-1:0] fill_word;
  logic [31:0]       walk_pos;

`ifdef PSRAM_TESTER_LFSR_EN
  localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));
  assign lfsr_next_o = lfsr_i[0] ? ((lfsr_i >> 1) ^ TAPS) : (lfsr_i >> 1);
`endif

  always_comb begin
    idx_word  = DATA_W'(idx_i);
    walk_pos  = 32'(idx_i) % 32'(DATA_W);
    walk_word = DATA_W'(1) << walk_pos;
    fill_word = '0;
    for (int b = 0; b < DATA_W; b++) begin
      fill_word[b] = FILL_WORD[4'(b % 16)];
    end
    case (mode_i)
      MODE_INDEX: word_o = idx_word;
      MODE_INV:   word_o = ~idx_word;
      MODE_WALK:  word_o = walk_word;
`ifdef PSRAM_TESTER_LFSR_EN
      default:    word_o = lfsr_i;
`else
      default:    word_o = fill_word;
`endif
    endcase
  end

endmodule

// File: rtl/psram_pattern_tester.sv
// rtl/psram_pattern_tester.sv - write/read-verify engine over 2**DEPTH_LOG2 words of the PSRAM port
// Optional LFSR pattern for mode 3 is enabled by defining PSRAM_TESTER_LFSR_EN.
module psram_pattern_tester
  import psram_tester_pkg::*;
#(
  parameter int                ADDR_W     = 24,
  parameter int                DATA_W     = 16,
  parameter int                DEPTH_LOG2 = 8,
  parameter int                ADDR_STEP  = 2,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                CNT_W      = 16,
  parameter logic [63:0]       LFSR_SEED  = 64'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 loop,
  input  logic [1:0]           mode,
  psram_pattern_tester_if.master mem,
  output logic                 busy,
  output logic                 pass_done,
  output logic [CNT_W-1:0]     pass_count,
  output logic [CNT_W-1:0]     err_count,
  output logic                 err_flag,
  output logic [ADDR_W-1:0]    err_addr,
  output logic [DATA_W-1:0]    err_expected,
  output logic [DATA_W-1:0]    err_actual
);

  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]      pass_cnt_q, pass_cnt_d;
  logic                  start_q;
  logic [CNT_W-1:0]      err_cnt_q;
  logic                  err_flag_q;
  logic [ADDR_W-1:0]     err_addr_q;
  logic [DATA_W-1:0]     err_exp_q, err_act_q;
  logic                  cmp_vld_q;
  logic [ADDR_W-1:0]     cmp_addr_q;
  logic [DATA_W-1:0]     cmp_exp_q, cmp_act_q;
  logic [DATA_W-1:0]     word;
  logic [ADDR_W-1:0]     cur_addr;
  logic                  go, word_done, wr_strb, rd_strb, pass_pulse;

  assign cur_addr  = BASE_ADDR + ADDR_W'(idx_q) * ADDR_W'(ADDR_STEP);
  assign go        = loop ? start : (start && !start_q);
  assign word_done = mem.mem_ready && (state_q == ST_WR_WAIT_HI || state_q == ST_RD_WAIT_HI);

`ifdef PSRAM_TESTER_LFSR_EN
  localparam logic [DATA_W-1:0] SEED = DATA_W'(LFSR_SEED);
  logic [DATA_W-1:0] lfsr_q, lfsr_d, lfsr_next;

  // Reload at the start of each phase so reads regenerate the written sequence.
  always_comb begin
    lfsr_d = lfsr_q;
    if (state_q == ST_IDLE || state_q == ST_PASS_END ||
        (state_q == ST_WR_WAIT_HI && word_done && idx_q == LAST_IDX)) begin
      lfsr_d = SEED;
    end else if (word_done) begin
      lfsr_d = lfsr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  psram_pattern_gen #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_gen (
    .idx_i(idx_q), .mode_i(mode_q), .lfsr_i(lfsr_q), .lfsr_next_o(lfsr_next), .word_o(word)
  );
`else
  psram_pattern_gen #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) u_gen (
    .idx_i(idx_q), .mode_i(mode_q), .word_o(word)
  );
`endif

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    idx_d      = idx_q;
    pass_cnt_d = pass_cnt_q;
    wr_strb    = 1'b0;
    rd_strb    = 1'b0;
    pass_pulse = 1'b0;
    case (state_q)
      ST_IDLE: if (go) begin
        state_d = ST_WR_ISSUE;
        mode_d  = mode_e'(mode);
        idx_d   = '0;
      end
      ST_WR_ISSUE: if (mem.mem_ready) begin
        wr_strb = 1'b1;
        state_d = ST_WR_WAIT_LO;
      end
      ST_WR_WAIT_LO: if (!mem.mem_ready) state_d = ST_WR_WAIT_HI;
      ST_WR_WAIT_HI: if (mem.mem_ready) begin
        idx_d   = idx_q + DEPTH_LOG2'(1);
        state_d = (idx_q == LAST_IDX) ? ST_RD_ISSUE : ST_WR_ISSUE;
      end
      ST_RD_ISSUE: if (mem.mem_ready) begin
        rd_strb = 1'b1;
        state_d = ST_RD_WAIT_LO;
      end
      ST_RD_WAIT_LO: if (!mem.mem_ready) state_d = ST_RD_WAIT_HI;
      ST_RD_WAIT_HI: if (mem.mem_ready) begin
        idx_d   = idx_q + DEPTH_LOG2'(1);
        state_d = (idx_q == LAST_IDX) ? ST_PASS_END : ST_RD_ISSUE;
      end
      ST_PASS_END: begin
        pass_pulse = 1'b1;
        pass_cnt_d = pass_cnt_q + CNT_W'(1);
        mode_d     = mode_e'(mode);
        state_d    = (loop && start) ? ST_WR_ISSUE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_INDEX;
      idx_q      <= '0;
      pass_cnt_q <= '0;
      start_q    <= 1'b0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
      err_addr_q <= '0;
      err_exp_q  <= '0;
      err_act_q  <= '0;
      cmp_vld_q  <= 1'b0;
      cmp_addr_q <= '0;
      cmp_exp_q  <= '0;
      cmp_act_q  <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      idx_q      <= idx_d;
      pass_cnt_q <= pass_cnt_d;
      start_q    <= start;
      cmp_vld_q  <= word_done && (state_q == ST_RD_WAIT_HI);
      if (word_done && state_q == ST_RD_WAIT_HI) begin
        cmp_addr_q <= cur_addr;
        cmp_exp_q  <= word;
        cmp_act_q  <= mem.mem_rdata;
      end
      // Only the first mismatch since reset is captured.
      if (cmp_vld_q && cmp_exp_q != cmp_act_q) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
        err_flag_q <= 1'b1;
        if (!err_flag_q) begin
          err_addr_q <= cmp_addr_q;
          err_exp_q  <= cmp_exp_q;
          err_act_q  <= cmp_act_q;
        end
      end
    end
  end

  assign mem.mem_write_strb = wr_strb;
  assign mem.mem_read_strb  = rd_strb;
  assign mem.mem_addr       = (state_q == ST_IDLE) ? '0 : cur_addr;
  assign mem.mem_wdata      = (state_q == ST_IDLE) ? '0 : word;
  assign busy               = (state_q != ST_IDLE);
  assign pass_done          = pass_pulse;
  assign pass_count         = pass_cnt_q;
  assign err_count          = err_cnt_q;
  assign err_flag           = err_flag_q;
  assign err_addr           = err_addr_q;
  assign err_expected       = err_exp_q;
  assign err_actual         = err_act_q;

endmodule

// File: tb/tb_psram_pattern_tester.sv
// tb/tb_psram_pattern_tester.sv - directed bench with a behavioural ready/strobe PSRAM controller
// Mode-3 expectations follow PSRAM_TESTER_LFSR_EN.
module tb_psram_pattern_tester;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        loop = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        busy, pass_done, err_flag;
  logic [15:0] pass_count, err_count, err_expected, err_actual;
  logic [23:0] err_addr;

  int vec_cnt = 0;
  int miss_cnt = 0;

  psram_pattern_tester_if #(.ADDR_W(24), .DATA_W(16)) mif ();

  psram_pattern_tester dut (
    .clk(clk), .rst(rst), .start(start), .loop(loop), .mode(mode), .mem(mif),
    .busy(busy), .pass_done(pass_done), .pass_count(pass_count), .err_count(err_count),
    .err_flag(err_flag), .err_addr(err_addr), .err_expected(err_expected), .err_actual(err_actual)
  );

  always #5 clk = ~clk;

  // Behavioural controller: ready drops for 5..20 cycles after each strobe.
  logic [15:0] mem_arr [256];
  logic        ready_m = 1'b1;
  logic [15:0] rdata_m = '0;
  logic        corrupt = 1'b0;
  logic [15:0] r17 = '0;
  int          lo_cnt = 0;

  assign mif.mem_ready = ready_m;
  assign mif.mem_rdata = rdata_m;

  always @(posedge clk) begin
    if (lo_cnt != 0) begin
      lo_cnt <= lo_cnt - 1;
      if (lo_cnt == 1) ready_m <= 1'b1;
    end else if (mif.mem_write_strb || mif.mem_read_strb) begin
      ready_m <= 1'b0;
      lo_cnt  <= int'($urandom_range(20, 5));
      if (mif.mem_write_strb) mem_arr[mif.mem_addr[8:1]] <= mif.mem_wdata;
      if (mif.mem_read_strb) begin
        rdata_m <= (corrupt && mif.mem_addr == 24'h10) ? 16'hDEAD : mem_arr[mif.mem_addr[8:1]];
        if (mif.mem_addr == 24'h22) r17 <= mem_arr[17];
      end
    end
  end

  int          wr_cnt, rd_cnt, addr_bad, non_a5, pd_cnt, viol;
  logic [23:0] last_wr_addr;
  logic [15:0] first_wd, second_wd, w17;

  always @(negedge clk) begin
    if (mif.mem_write_strb) begin
      if (mif.mem_addr !== 24'(2 * (wr_cnt % 256))) addr_bad++;
      if (wr_cnt == 0) first_wd = mif.mem_wdata;
      if (wr_cnt == 1) second_wd = mif.mem_wdata;
      if (mif.mem_addr == 24'h22) w17 = mif.mem_wdata;
      if (mif.mem_wdata != 16'hA5A5) non_a5++;
      last_wr_addr = mif.mem_addr;
      wr_cnt++;
    end
    if (mif.mem_read_strb) begin
      if (mif.mem_addr !== 24'(2 * (rd_cnt % 256))) addr_bad++;
      rd_cnt++;
    end
    if ((mif.mem_write_strb || mif.mem_read_strb) && !mif.mem_ready) viol++;
    if (pass_done) pd_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cnt = 0; rd_cnt = 0; addr_bad = 0; non_a5 = 0; pd_cnt = 0;
    last_wr_addr = '0; first_wd = '0; second_wd = '0; w17 = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clear_mon();
  endtask

  task automatic wait_pd(input int n);
    for (int c = 0; c < 30000; c++) begin
      if (pd_cnt >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic run_one(input logic [1:0] m);
    mode = m; loop = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); @(posedge clk); #1 start = 1'b0;
    wait_pd(1);
    repeat (4) @(negedge clk);
  endtask

  int got_rd;

  initial begin
    viol = 0;
    clear_mon();
    repeat (4) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wstrb", mif.mem_write_strb, 0);
    check_eq("rst_rstrb", mif.mem_read_strb, 0);
    check_eq("rst_addr", mif.mem_addr, 0);
    check_eq("rst_wdata", mif.mem_wdata, 0);
    check_eq("rst_pass_done", pass_done, 0);
    check_eq("rst_pass_count", pass_count, 0);
    check_eq("rst_err_count", err_count, 0);
    check_eq("rst_err_flag", err_flag, 0);
    check_eq("rst_err_fields", {err_addr[15:0], err_expected | err_actual}, 0);
    do_reset();

    // 1: index pattern, single pass
    run_one(2'd0);
    check_eq("t1_pass_done", pd_cnt, 1);
    check_eq("t1_writes", wr_cnt, 256);
    check_eq("t1_reads", rd_cnt, 256);
    check_eq("t1_addr_seq", addr_bad, 0);
    check_eq("t1_last_addr", last_wr_addr, 24'h0001FE);
    check_eq("t1_word17", w17, 16'h0011);
    check_eq("t1_err_count", err_count, 0);
    check_eq("t1_pass_count", pass_count, 1);
    check_eq("t1_busy", busy, 0);

    // 2: walking one
    do_reset();
    run_one(2'd2);
    check_eq("t2_word17_wr", w17, 16'h0002);
    check_eq("t2_word17_rd", r17, 16'h0002);
    check_eq("t2_pass_count", pass_count, 1);
    check_eq("t2_err_flag", err_flag, 0);

    // 3: single corrupted read
    do_reset();
    corrupt = 1'b1;
    run_one(2'd0);
    check_eq("t3_err_count", err_count, 1);
    check_eq("t3_err_flag", err_flag, 1);
    check_eq("t3_err_addr", err_addr, 24'h000010);
    check_eq("t3_err_expected", err_expected, 16'h0008);
    check_eq("t3_err_actual", err_actual, 16'hDEAD);

    // 4: looping, three corrupted passes
    do_reset();
    mode = 2'd1; loop = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    wait_pd(2);
    @(posedge clk); #1 start = 1'b0;
    wait_pd(3);
    repeat (4) @(negedge clk);
    check_eq("t4_pass_done", pd_cnt, 3);
    check_eq("t4_pass_count", pass_count, 3);
    check_eq("t4_err_count", err_count, 3);
    check_eq("t4_err_addr", err_addr, 24'h000010);
    check_eq("t4_err_expected", err_expected, 16'hFFF7);
    check_eq("t4_err_actual", err_actual, 16'hDEAD);
    check_eq("t4_idle", busy, 0);
    loop = 1'b0;

    // 5: reset while waiting on a read
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    got_rd = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (mif.mem_read_strb) begin got_rd = 1; break; end
    end
    check_eq("t5_reached_read", got_rd, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_eq("t5_strobes", {mif.mem_write_strb, mif.mem_read_strb}, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_pass_count", pass_count, 0);
    check_eq("t5_err_count", err_count, 0);
    check_eq("t5_err_flag", err_flag, 0);
    clear_mon();
    repeat (40) @(negedge clk);
    check_eq("t5_no_strobe", wr_cnt + rd_cnt, 0);

    // 6: mode 3
    do_reset();
    corrupt = 1'b0;
    run_one(2'd3);
    check_eq("t6_pass_done", pd_cnt, 1);
    check_eq("t6_writes", wr_cnt, 256);
    check_eq("t6_err_count", err_count, 0);
`ifdef PSRAM_TESTER_LFSR_EN
    check_eq("t6_first_word", first_wd, 16'hACE1);
    check_eq("t6_second_word", second_wd, 16'hE270);
`else
    check_eq("t6_first_word", first_wd, 16'hA5A5);
    check_eq("t6_non_fill", non_a5, 0);
`endif

    check_eq("strobe_while_busy", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
